// File: rtl/flash_seq_stepper.sv
// Defers flash-clock step requests to the next frame boundary, then advances pattern index and blink phase.
// Optional build macro FLASH_SEQ_PINGPONG_EN selects ping-pong stepping instead of wrap-around.
module flash_seq_stepper #(
    parameter int NUM_PATTERNS = 8,
    parameter int IDX_W        = 3,
    parameter int BLINK_DIV    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             frame_start,
    input  logic             run,
    input  logic             step_req,
    output logic [IDX_W-1:0] pattern_idx,
    output logic             blink,
    output logic             update,
    output logic             pending
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             req;
    logic             apply_step;
    logic [CNT_W-1:0] blink_cnt;
    logic [IDX_W-1:0] idx_nxt;

    // A tick while stopped is dropped; a manual step always counts.
    assign req = (tick & run) | step_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = frame_start ? APPLY : PEND;
            PEND:    if (frame_start) state_nxt = APPLY;
            APPLY:   state_nxt = req ? PEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        apply_step = (state == APPLY);
        pending    = (state == PEND);
    end

`ifdef FLASH_SEQ_PINGPONG_EN
    logic dir_up;
    logic dir_up_nxt;

    always_comb begin
        idx_nxt    = pattern_idx;
        dir_up_nxt = dir_up;
        if (NUM_PATTERNS > 1) begin
            if (dir_up) begin
                if (pattern_idx == LAST_IDX) begin
                    idx_nxt    = pattern_idx - IDX_W'(1);
                    dir_up_nxt = 1'b0;
                end else begin
                    idx_nxt = pattern_idx + IDX_W'(1);
                end
            end else begin
                if (pattern_idx == '0) begin
                    idx_nxt    = pattern_idx + IDX_W'(1);
                    dir_up_nxt = 1'b1;
                end else begin
                    idx_nxt = pattern_idx - IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dir_up <= 1'b1;
        else if (apply_step)
            dir_up <= dir_up_nxt;
    end
`else
    // Wrap compare also covers NUM_PATTERNS==1, where LAST_IDX is 0 and the index stays put.
    always_comb begin
        idx_nxt = (pattern_idx == LAST_IDX) ? '0 : pattern_idx + IDX_W'(1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_idx <= '0;
            blink       <= 1'b0;
            blink_cnt   <= '0;
            update      <= 1'b0;
        end else begin
            update <= apply_step;
            if (apply_step) begin
                pattern_idx <= idx_nxt;
                if (blink_cnt == LAST_CNT) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_seq_stepper.sv
// Scoreboard bench for flash_seq_stepper: the stimulus side predicts each step's index/blink and arrival cycle.
// Define FLASH_SEQ_PINGPONG_EN to exercise the ping-pong build with four patterns.
module tb_flash_seq_stepper;

`ifdef FLASH_SEQ_PINGPONG_EN
    localparam int NP = 4;
`else
    localparam int NP = 8;
`endif
    localparam int IW = 3;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          frame_start = 1'b0;
    logic          run = 1'b0;
    logic          step_req = 1'b0;
    logic [IW-1:0] pattern_idx;
    logic          blink;
    logic          update;
    logic          pending;

    flash_seq_stepper #(.NUM_PATTERNS(NP), .IDX_W(IW), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .tick(tick), .frame_start(frame_start),
        .run(run), .step_req(step_req), .pattern_idx(pattern_idx),
        .blink(blink), .update(update), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [IW-1:0] idx;
        logic          blink;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   steps_done = 0;
    bit   m_latched = 0;
    bit   m_apply = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Index after k applied steps, from the stepping rule rather than any state machine.
    function automatic logic [IW-1:0] model_idx(input int k);
        int p;
        if (NP == 1) return '0;
`ifdef FLASH_SEQ_PINGPONG_EN
        p = k % (2 * NP - 2);
        if (p >= NP) p = 2 * NP - 2 - p;
`else
        p = k % NP;
`endif
        return IW'(p);
    endfunction

    function automatic logic model_blink(input int k);
        return ((k / BD) % 2) == 1;
    endfunction

    task automatic do_cycle(input bit t, input bit fs, input bit r, input bit sr);
        bit req;
        @(negedge clk);
        checks++;
        if (pending !== m_latched) begin
            failures++;
            $display("FAIL pending cyc=%0d got=%b exp=%b", cyc, pending, m_latched);
        end
        tick = t; frame_start = fs; run = r; step_req = sr;
        req = (t && r) || sr;
        if (m_apply) begin
            steps_done++;
            q.push_back('{cyc + 1, model_idx(steps_done), model_blink(steps_done)});
            m_apply   = 0;
            m_latched = req;
        end else if (m_latched || req) begin
            if (fs) begin
                m_apply   = 1;
                m_latched = 0;
            end else begin
                m_latched = 1;
            end
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) do_cycle(0, 0, r, 0);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (pattern_idx !== '0 || pending !== 1'b0 || update !== 1'b0 || blink !== 1'b0) begin
            failures++;
            $display("FAIL %s got idx=%0d pend=%b upd=%b blink=%b exp all 0",
                     tag, pattern_idx, pending, update, blink);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        tick = 0; frame_start = 0; step_req = 0;
        reset = 1;
        #1;
        check_reset_values("reset_async");
        m_latched = 0; m_apply = 0; steps_done = 0;
        q.delete();
        @(negedge clk);
        reset = 0;
    endtask

    // Monitor: every update pulse must match the head of the expectation queue at its exact cycle.
    always @(posedge clk) begin
        exp_t e;
        bit   hit;
        #1;
        if (!reset) begin
            hit = (q.size() > 0) && (q[0].cyc == cyc);
            if (update || hit) begin
                checks++;
                if (!hit) begin
                    failures++;
                    $display("FAIL unexpected_update cyc=%0d idx=%0d", cyc, pattern_idx);
                end else begin
                    e = q.pop_front();
                    if (update !== 1'b1 || pattern_idx !== e.idx || blink !== e.blink) begin
                        failures++;
                        $display("FAIL step cyc=%0d got upd=%b idx=%0d blink=%b exp upd=1 idx=%0d blink=%b",
                                 cyc, update, pattern_idx, blink, e.idx, e.blink);
                    end
                end
            end
            if (q.size() > 0 && q[0].cyc < cyc) begin
                failures++;
                $display("FAIL missed_update exp_cyc=%0d now=%0d", q[0].cyc, cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #1;
        check_reset_values("reset_initial");
        repeat (2) @(negedge clk);
        reset = 0;

        // Reset while a step is pending: the step must be lost.
        do_cycle(1, 0, 1, 0);
        idle(5, 1);
        apply_reset();
        do_cycle(0, 1, 1, 0);
        idle(4, 1);

        // Long wait between tick and frame boundary.
        idle(5, 1);
        do_cycle(1, 0, 1, 0);
        idle(39, 1);
        do_cycle(0, 1, 1, 0);
        idle(4, 1);

        // Several ticks coalesce into one step.
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, 0, 1, 0);
            idle(2, 1);
        end
        do_cycle(0, 1, 1, 0);
        idle(4, 1);

        // Stopped: tick ignored, manual step honoured.
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 0, 0);
        idle(3, 0);
        do_cycle(0, 0, 0, 1);
        do_cycle(0, 1, 0, 0);
        idle(3, 0);

        // Nine consecutive steps from reset across the wrap point.
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_cycle(1, 0, 1, 0);
            do_cycle(0, 1, 1, 0);
            idle(3, 1);
        end

        // Request and frame boundary together from IDLE, plus back-to-back requests during APPLY.
        do_cycle(1, 1, 1, 0);
        do_cycle(0, 0, 1, 1);
        idle(2, 1);
        do_cycle(0, 1, 1, 0);
        idle(4, 1);

        for (int i = 0; i < 3000; i++) begin
            do_cycle(($urandom % 8) == 0, ($urandom % 12) == 0,
                     ($urandom % 4) != 0, ($urandom % 40) == 0);
            if (i == 1500) apply_reset();
        end

        idle(8, 0);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain leftover=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
